serie_paralelo: RTL and testbench
=================================

# serie_paralelo

Receive-side serial-to-parallel converter for one PHY lane, running entirely on `clk_8f`. It takes the MSB-first serial bitstream produced by the transmit lane serializer and finds byte alignment by hunting for the COM symbol. It declares the lane active after `COM_NEEDED` consecutive aligned COMs, then delivers each received byte with a valid flag and a one-cycle strobe. The block feeds the receive-side byte un-striping stage; one instance is used per lane.

## Interface
- `COM_SYMBOL`, default `8'hBC`: filler symbol the transmitter sends when its lane is not valid.
- `COM_NEEDED`, default `4`: consecutive aligned COMs required to reach ACTIVE; legal range is 1..15.
- `clk_8f` input 1: bit clock; all logic is on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state and outputs immediately.
- `data_inS` input 1: serial data, MSB first, one bit per `clk_8f` edge.
- `data_outP` output 8: last received non-COM byte.
- `valid_out` output 1: 1 when the last completed byte was data, 0 when it was COM.
- `byte_strobe` output 1: one-cycle pulse on each byte completion while ACTIVE.
- `active` output 1: lane aligned and delivering bytes.
- `byte_count` output 16: only present with `SP_BYTE_COUNT_EN` (see Configuration).

## Operation
- Shift register `sr[7:0]` takes `data_inS` at bit 0 every cycle in every state. The incoming byte `nb` is `{sr[6:0], data_inS}`.
- 3-bit bit counter `bc` and 4-bit COM counter `cc`.
- States:
  - **SEARCH** (reset state):
    - Every cycle, if `nb == COM_SYMBOL`, set `bc <= 0` and `cc <= 1`.
    - Then go to ACTIVE if `COM_NEEDED == 1`, otherwise go to LOCK.
  - **LOCK**:
    - `bc` increments each cycle. A byte is complete when `bc == 7` (the 8th bit after the previous boundary); `bc` wraps to 0.
    - At byte completion, if `nb == COM_SYMBOL`, increment `cc`. When `cc + 1 == COM_NEEDED`, go to ACTIVE and set `active <= 1`.
    - At byte completion, if `nb != COM_SYMBOL`, go to SEARCH and clear `cc`. Partial COM counts are never retained.
  - **ACTIVE**:
    - At each byte completion, set `byte_strobe <= 1`.
    - If `nb != COM_SYMBOL`: `data_outP <= nb` and `valid_out <= 1`.
    - If `nb == COM_SYMBOL`: `valid_out <= 0` and `data_outP` holds its value.
    - Between completions, `byte_strobe <= 0`, and `data_outP` and `valid_out` hold.
    - ACTIVE is left only by `reset`; there is no loss-of-lock detection.
- A data byte whose value equals `COM_SYMBOL` is indistinguishable from filler. This is a protocol restriction, not detected here.

## Timing
- Reset values: `data_outP = 8'h00`, `valid_out = 0`, `byte_strobe = 0`, `active = 0`, `byte_count = 0`, `sr = 0`, `bc = 0`, `cc = 0`, state SEARCH.
- All outputs are registered. When the last bit of a byte is sampled at edge N, the outputs reflect that byte after edge N. First bit to output is 7 cycles of latency.
- `active` rises at the edge sampling the last bit of the `COM_NEEDED`-th COM. The first `byte_strobe` comes 8 edges later.
- `byte_strobe` is high for exactly 1 of every 8 cycles while ACTIVE and is never high outside ACTIVE.
- Reset asserted mid-byte or mid-lock clears everything asynchronously. After release, the search restarts from an empty shift register.

## Configuration
- `SP_BYTE_COUNT_EN` defined:
  - Adds the `byte_count` output port, a 16-bit counter.
  - It increments at each ACTIVE byte completion with a non-COM byte and wraps from `16'hFFFF` to 0.
  - It is cleared only by `reset`.
- `SP_BYTE_COUNT_EN` undefined: no port and no counter logic. All other behaviour is identical.

## Test plan
- Reset held while random bits drive `data_inS`: all outputs stay 0 and `active` stays 0.
- Three garbage bits `101`, then four `8'hBC` bytes: `active` rises at the edge of the 35th bit (the last bit of the 4th COM); `byte_strobe` stays 0 until then.
- After lock, send `8'hA5`: 8 edges later `data_outP = 8'hA5`, `valid_out = 1`, one-cycle `byte_strobe`. Then send `8'hBC`: `valid_out = 0`, `data_outP` stays `8'hA5`, strobe pulses.
- Send two COMs, then `8'h3C`: the block returns to SEARCH with `active = 0`. Four fresh COMs are then needed, and `active` rises only after the 4th.
- Send bytes `8'h11`, `8'h22`, `8'hBC`, `8'h33` while ACTIVE: `byte_count = 3` (with `SP_BYTE_COUNT_EN`). Assert `reset` mid-byte: all outputs, including `byte_count`, read 0 immediately.

Source files
------------

// File: rtl/serie_paralelo_if.sv
// Lane interface for the serial-to-parallel receiver.
// Carries the serial input bit and the parallel byte outputs.
// With SP_BYTE_COUNT_EN defined, it also carries the 16-bit delivered-byte counter.
interface serie_paralelo_if;
    logic       data_inS;
    logic [7:0] data_outP;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;
`ifdef SP_BYTE_COUNT_EN
    logic [15:0] byte_count;
`endif

`ifdef SP_BYTE_COUNT_EN
    // Serializer side: drives the bitstream and observes the delivered bytes
    modport master (
        output data_inS,
        input  data_outP,
        input  valid_out,
        input  byte_strobe,
        input  active,
        input  byte_count
    );

    // Receiver side: the serie_paralelo block itself
    modport slave (
        input  data_inS,
        output data_outP,
        output valid_out,
        output byte_strobe,
        output active,
        output byte_count
    );
`else
    // Serializer side: drives the bitstream and observes the delivered bytes
    modport master (
        output data_inS,
        input  data_outP,
        input  valid_out,
        input  byte_strobe,
        input  active
    );

    // Receiver side: the serie_paralelo block itself
    modport slave (
        input  data_inS,
        output data_outP,
        output valid_out,
        output byte_strobe,
        output active
    );
`endif
endinterface

// File: rtl/serie_paralelo.sv
// Receive-side serial-to-parallel converter for one PHY lane.
// It hunts for the COM symbol in the MSB-first bitstream to find byte alignment.
// It declares the lane active after COM_NEEDED consecutive aligned COMs.
// Once active, it delivers each byte with a valid flag and a one-cycle strobe.
// Optional feature: define SP_BYTE_COUNT_EN to add the 16-bit byte_count output.
module serie_paralelo #(
    parameter logic [7:0]  COM_SYMBOL = 8'hBC,
    parameter int unsigned COM_NEEDED = 4
) (
    input logic             clk_8f,
    input logic             reset,
    serie_paralelo_if.slave lane
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [3:0] COM_NEEDED_W = 4'(COM_NEEDED);

    // The oldest bit of the 8-bit window ages out as the new bit arrives.
    // Only the seven most recent bits need to be kept between edges.
    logic [6:0] sr;
    logic [2:0] bc;
    logic [3:0] cc;
    state_t     state;

    logic [7:0] nb;
    logic       is_com;
    logic       byte_done;

    assign nb        = {sr, lane.data_inS};
    assign is_com    = (nb == COM_SYMBOL);
    assign byte_done = (bc == 3'd7);

    // Alignment FSM plus registered byte outputs, all advancing on the bit clock
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            sr               <= '0;
            bc               <= '0;
            cc               <= '0;
            state            <= SEARCH;
            lane.data_outP   <= 8'h00;
            lane.valid_out   <= 1'b0;
            lane.byte_strobe <= 1'b0;
            lane.active      <= 1'b0;
`ifdef SP_BYTE_COUNT_EN
            lane.byte_count  <= 16'h0000;
`endif
        end else begin
            sr               <= nb[6:0];
            lane.byte_strobe <= 1'b0;
            case (state)
                SEARCH: begin
                    if (is_com) begin
                        bc <= 3'd0;
                        cc <= 4'd1;
                        if (COM_NEEDED_W == 4'd1) begin
                            state       <= ACTIVE;
                            lane.active <= 1'b1;
                        end else begin
                            state <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    bc <= bc + 3'd1;
                    if (byte_done) begin
                        if (is_com) begin
                            cc <= cc + 4'd1;
                            if (cc + 4'd1 == COM_NEEDED_W) begin
                                state       <= ACTIVE;
                                lane.active <= 1'b1;
                            end
                        end else begin
                            state <= SEARCH;
                            cc    <= 4'd0;
                        end
                    end
                end
                ACTIVE: begin
                    bc <= bc + 3'd1;
                    if (byte_done) begin
                        lane.byte_strobe <= 1'b1;
                        if (is_com) begin
                            lane.valid_out <= 1'b0;
                        end else begin
                            lane.data_outP <= nb;
                            lane.valid_out <= 1'b1;
`ifdef SP_BYTE_COUNT_EN
                            lane.byte_count <= lane.byte_count + 16'd1;
`endif
                        end
                    end
                end
                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serie_paralelo.sv
// Self-checking bench for serie_paralelo.
// Expected bytes are queued as they are serialized and popped on each byte_strobe.
module tb_serie_paralelo;

    localparam logic [7:0] COM = 8'hBC;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
    } exp_t;

    logic clk_8f = 1'b0;
    logic reset  = 1'b1;

    int num_checks = 0;
    int num_passed = 0;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] last_data = 8'h00;

    serie_paralelo_if lane_if();

    serie_paralelo #(
        .COM_SYMBOL(COM),
        .COM_NEEDED(4)
    ) dut (
        .clk_8f(clk_8f),
        .reset (reset),
        .lane  (lane_if)
    );

    // Bit clock
    always #5 clk_8f = ~clk_8f;

    // Scoreboard monitor: every strobe must match the next queued byte
    always @(negedge clk_8f) begin
        if (!reset && lane_if.byte_strobe === 1'b1) begin
            num_checks++;
            if (sb.size() == 0) begin
                $display("[TB] FAIL unexpected_strobe: byte_strobe=1 with no byte queued, required 0");
            end else begin
                mon_e = sb.pop_front();
                if (lane_if.data_outP === mon_e.data && lane_if.valid_out === mon_e.valid)
                    num_passed++;
                else
                    $display("[TB] FAIL sb_byte: data_outP=%h valid_out=%b, required %h/%b",
                             lane_if.data_outP, lane_if.valid_out, mon_e.data, mon_e.valid);
            end
        end
    end

    task automatic send_bit(input logic b);
        lane_if.data_inS = b;
        @(posedge clk_8f);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        last_data = 8'h00;
        lane_if.data_inS = 1'b0;
        @(posedge clk_8f);
        #1;
        reset = 1'b0;
    endtask

    // Sends one byte before lock; checks that active rises only on the last bit when expected
    task automatic send_search_byte(input logic [7:0] v, input logic rise_on_last);
        logic exp_act;
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            exp_act = (i == 0) ? rise_on_last : 1'b0;
            num_checks++;
            if (lane_if.active === exp_act) num_passed++;
            else $display("[TB] FAIL active_timing: active=%b at bit %0d of %h, required %b",
                          lane_if.active, 7 - i, v, exp_act);
        end
    endtask

    // Sends one byte while active, queueing its expected output and checking strobe timing
    task automatic send_byte(input logic [7:0] v);
        exp_t e;
        if (v == COM) begin
            e.data  = last_data;
            e.valid = 1'b0;
        end else begin
            e.data    = v;
            e.valid   = 1'b1;
            last_data = v;
        end
        sb.push_back(e);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
            num_checks++;
            if (lane_if.byte_strobe === (i == 0)) num_passed++;
            else $display("[TB] FAIL strobe_timing: byte_strobe=%b at bit %0d of %h, required %b",
                          lane_if.byte_strobe, 7 - i, v, (i == 0));
        end
    endtask

    task automatic drain();
        @(negedge clk_8f);
        #1;
        num_checks++;
        if (sb.size() == 0) num_passed++;
        else $display("[TB] FAIL sb_drain: %0d bytes never strobed, required 0", sb.size());
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            lane_if.data_inS = 1'($urandom);
            @(posedge clk_8f);
            #1;
            num_checks++;
            if (lane_if.data_outP === 8'h00 && lane_if.valid_out === 1'b0 &&
                lane_if.byte_strobe === 1'b0 && lane_if.active === 1'b0)
                num_passed++;
            else
                $display("[TB] FAIL reset_hold: data=%h valid=%b strobe=%b active=%b, required all 0",
                         lane_if.data_outP, lane_if.valid_out, lane_if.byte_strobe, lane_if.active);
        end
`ifdef SP_BYTE_COUNT_EN
        num_checks++;
        if (lane_if.byte_count === 16'h0000) num_passed++;
        else $display("[TB] FAIL reset_count: byte_count=%h, required 0000", lane_if.byte_count);
`endif
    endtask

    task automatic test_lock();
        logic [2:0] garbage;
        do_reset();
        garbage = 3'b101;
        for (int i = 2; i >= 0; i--) begin
            send_bit(garbage[i]);
            num_checks++;
            if (lane_if.active === 1'b0) num_passed++;
            else $display("[TB] FAIL garbage_active: active=%b, required 0", lane_if.active);
        end
        send_search_byte(COM, 1'b0);
        send_search_byte(COM, 1'b0);
        send_search_byte(COM, 1'b0);
        send_search_byte(COM, 1'b1);
    endtask

    task automatic test_data();
        send_byte(8'hA5);
        send_byte(COM);
        num_checks++;
        if (lane_if.data_outP === 8'hA5 && lane_if.valid_out === 1'b0) num_passed++;
        else $display("[TB] FAIL com_hold: data=%h valid=%b, required a5/0",
                      lane_if.data_outP, lane_if.valid_out);
        drain();
    endtask

    task automatic test_relock();
        do_reset();
        send_search_byte(COM, 1'b0);
        send_search_byte(COM, 1'b0);
        send_search_byte(8'h3C, 1'b0);
        send_search_byte(COM, 1'b0);
        send_search_byte(COM, 1'b0);
        send_search_byte(COM, 1'b0);
        send_search_byte(COM, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        v = 8'h44;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(COM);
        send_byte(8'h33);
        drain();
`ifdef SP_BYTE_COUNT_EN
        num_checks++;
        if (lane_if.byte_count === 16'd3) num_passed++;
        else $display("[TB] FAIL byte_count: byte_count=%0d, required 3", lane_if.byte_count);
`endif
        for (int i = 7; i >= 4; i--) send_bit(v[i]);
        reset = 1'b1;
        sb.delete();
        #1;
        num_checks++;
        if (lane_if.data_outP === 8'h00 && lane_if.valid_out === 1'b0 &&
            lane_if.byte_strobe === 1'b0 && lane_if.active === 1'b0)
            num_passed++;
        else
            $display("[TB] FAIL async_reset: data=%h valid=%b strobe=%b active=%b, required all 0",
                     lane_if.data_outP, lane_if.valid_out, lane_if.byte_strobe, lane_if.active);
`ifdef SP_BYTE_COUNT_EN
        num_checks++;
        if (lane_if.byte_count === 16'h0000) num_passed++;
        else $display("[TB] FAIL async_reset_count: byte_count=%h, required 0000", lane_if.byte_count);
`endif
        @(posedge clk_8f);
        #1;
        reset = 1'b0;
    endtask

    // Scenario sequence: lock from a clean reset, then each delivery case in turn
    initial begin
        lane_if.data_inS = 1'b0;
        $display("[TB] start");
        test_reset();
        test_lock();
        test_data();
        test_relock();
        test_back_to_back();
        $display("%0d/%0d checks passed", num_passed, num_checks);
        $finish;
    end

endmodule
